// File: rtl/quad_step_decoder.sv
module quad_step_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic quad_a,
  input  logic quad_b,
  output logic enable,
  output logic up_down,
  output logic err
);

  localparam int unsigned WARMUP    = SYNC_STAGES + FILTER_LEN + 2;
  localparam logic [4:0]  WARMUP_W  = 5'(WARMUP);
  localparam logic [3:0]  FILT_LAST = 4'(FILTER_LEN - 1);

  // Channel index 1 = A, 0 = B, so {filt[1], filt[0]} reads as {fa, fb}.
  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [1:0]             synced;
  logic [3:0]             cnt_q  [2];
  logic [3:0]             cnt_d  [2];
  logic [1:0]             filt_q, filt_d;
  logic [1:0]             prev_q;
  logic [4:0]             warm_q, warm_d;
  logic                   warm_done;
  logic [1:0]             moved;
  logic                   enable_q, enable_d;
  logic                   err_q, err_d;
  logic                   up_down_q, up_down_d;

  assign raw    = {quad_a, quad_b};
  assign synced = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};

  always_comb begin
    filt_d = filt_q;
    for (int unsigned ch = 0; ch < 2; ch++) begin
      cnt_d[ch] = '0;
      if (synced[ch] != filt_q[ch]) begin
        if (cnt_q[ch] == FILT_LAST) begin
          filt_d[ch] = synced[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 4'd1;
        end
      end
    end
  end

  assign warm_done = (warm_q == WARMUP_W);
  assign moved     = filt_q ^ prev_q;
  assign warm_d    = warm_done ? warm_q : warm_q + 5'd1;

  always_comb begin
    enable_d  = 1'b0;
    err_d     = 1'b0;
    up_down_d = up_down_q;
    if (warm_done) begin
      case (moved)
        2'b00: ;
        2'b11: err_d = 1'b1;
        default: begin
          enable_d  = 1'b1;
          // For a single-bit Gray move, prev A xor new B is 1 exactly on forward steps.
          up_down_d = prev_q[1] ^ filt_q[0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        sync_q[ch] <= '0;
        cnt_q[ch]  <= '0;
      end
      filt_q    <= '0;
      prev_q    <= '0;
      warm_q    <= '0;
      enable_q  <= 1'b0;
      err_q     <= 1'b0;
      up_down_q <= 1'b1;
    end else begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
        cnt_q[ch]  <= cnt_d[ch];
      end
      filt_q    <= filt_d;
      prev_q    <= filt_q;
      warm_q    <= warm_d;
      enable_q  <= enable_d;
      err_q     <= err_d;
      up_down_q <= up_down_d;
    end
  end

  assign enable  = enable_q;
  assign err     = err_q;
  assign up_down = up_down_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
module tb_quad_step_decoder;

  localparam int S      = 2;
  localparam int F      = 4;
  localparam int WARMUP = S + F + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic quad_a = 1'b0;
  logic quad_b = 1'b0;
  logic enable, up_down, err;

  quad_step_decoder #(.SYNC_STAGES(S), .FILTER_LEN(F)) dut (
    .clk     (clk),
    .rst     (rst),
    .quad_a  (quad_a),
    .quad_b  (quad_b),
    .enable  (enable),
    .up_down (up_down),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: delay line as a queue, filter as a run-length count,
  // decode as a difference of positions around the Gray cycle.
  bit [1:0] sq[$];
  bit [1:0] mf, mprev;
  int       mrun[2];
  int       mwarm;
  bit       men, mer, mud;

  function automatic int gpos(input bit [1:0] v);
    case (v)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_step(input bit a, input bit b, input bit r);
    bit [1:0] s, old_f, old_prev;
    int       old_warm, d;
    if (r) begin
      sq.delete();
      for (int i = 0; i < S; i++) sq.push_back(2'b00);
      mf = 2'b00; mprev = 2'b00; mrun[0] = 0; mrun[1] = 0;
      mwarm = 0; men = 0; mer = 0; mud = 1;
      return;
    end
    s = sq.pop_front();
    sq.push_back({a, b});
    old_f = mf; old_prev = mprev; old_warm = mwarm;
    for (int ch = 0; ch < 2; ch++) begin
      if (s[ch] != mf[ch]) begin
        mrun[ch]++;
        if (mrun[ch] == F) begin
          mf[ch]   = s[ch];
          mrun[ch] = 0;
        end
      end else begin
        mrun[ch] = 0;
      end
    end
    men = 0; mer = 0;
    if (old_warm < WARMUP) begin
      mwarm++;
    end else begin
      d = (gpos(old_f) - gpos(old_prev) + 4) % 4;
      if (d == 1) begin men = 1; mud = 1; end
      else if (d == 3) begin men = 1; mud = 0; end
      else if (d == 2) mer = 1;
    end
    mprev = old_f;
  endtask

  int       edge_no = 0;
  int       pulses = 0;
  int       errs = 0;
  int       position = 0;
  bit       lat_arm = 0;
  int       lat_edge = 0;
  bit [1:0] cur = 2'b00;

  task automatic cycle(input bit [1:0] ab, input bit r);
    quad_a = ab[1];
    quad_b = ab[0];
    rst    = r;
    @(posedge clk);
    model_step(ab[1], ab[0], r);
    edge_no++;
    #1;
    check("enable", 32'(enable), 32'(men));
    check("up_down", 32'(up_down), 32'(mud));
    check("err", 32'(err), 32'(mer));
    if (enable === 1'b1) begin
      pulses++;
      position += (up_down === 1'b1) ? 1 : -1;
      if (lat_arm) begin
        lat_edge = edge_no;
        lat_arm  = 0;
      end
    end
    if (err === 1'b1) errs++;
    cur = ab;
  endtask

  task automatic hold(input bit [1:0] ab, input int n);
    for (int i = 0; i < n; i++) cycle(ab, 1'b0);
  endtask

  initial begin
    int p0, e0, edge0;
    bit [1:0] nxt;
    int hl;

    // Reset state
    cycle(2'b00, 1'b1);
    cycle(2'b00, 1'b1);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_up_down", 32'(up_down), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    hold(2'b00, 12);

    // Forward sequence
    position = 0; p0 = pulses; e0 = errs;
    hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
    check("fwd_count", 32'(position), 32'd4);
    check("fwd_pulses", 32'(pulses - p0), 32'd4);
    check("fwd_errs", 32'(errs - e0), 32'd0);

    // Reverse sequence with latency measurement
    p0 = pulses; edge0 = edge_no; lat_arm = 1;
    hold(2'b10, 10);
    check("latency", 32'(lat_edge - edge0), 32'(S + F + 1));
    hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
    check("rev_count", 32'(position), 32'd0);
    check("rev_pulses", 32'(pulses - p0), 32'd4);

    // Glitch shorter than the filter, then a held change
    p0 = pulses; e0 = errs;
    hold(2'b10, F - 1); hold(2'b00, 12);
    check("glitch_pulses", 32'(pulses - p0), 32'd0);
    check("glitch_errs", 32'(errs - e0), 32'd0);
    hold(2'b10, F + 8);
    check("held_pulses", 32'(pulses - p0), 32'd1);
    hold(2'b00, 12);

    // Illegal double transition, then a legal up step
    p0 = pulses; e0 = errs;
    hold(2'b11, 12);
    check("dbl_errs", 32'(errs - e0), 32'd1);
    check("dbl_pulses", 32'(pulses - p0), 32'd0);
    hold(2'b10, 12);
    check("after_dbl_pulses", 32'(pulses - p0), 32'd1);
    check("after_dbl_dir", 32'(up_down), 32'd1);
    hold(2'b00, 12);

    // Non-zero level held through reset
    p0 = pulses; e0 = errs;
    cycle(2'b11, 1'b1); cycle(2'b11, 1'b1);
    hold(2'b11, 3 * WARMUP);
    check("warm_pulses", 32'(pulses - p0), 32'd0);
    check("warm_errs", 32'(errs - e0), 32'd0);
    check("warm_dir", 32'(up_down), 32'd1);

    // Reset in the middle of a forward sequence
    cycle(2'b00, 1'b1);
    hold(2'b00, 12);
    hold(2'b01, 10);
    hold(2'b11, F + 2);
    cycle(2'b11, 1'b1);
    check("midrst_enable", 32'(enable), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_dir", 32'(up_down), 32'd1);
    hold(2'b00, 14);
    p0 = pulses;
    hold(2'b10, 10);
    hold(2'b11, 10);
    check("resume_pulses", 32'(pulses - p0), 32'd2);

    // Randomised activity against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        cycle(cur, 1'b1);
      end else begin
        nxt = cur;
        if ($urandom_range(0, 9) < 7) nxt[$urandom_range(0, 1)] ^= 1'b1;
        else nxt = 2'($urandom_range(0, 3));
        hl = $urandom_range(1, 12);
        hold(nxt, hl);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
